lcd_value_display: RTL and testbench

LCD_VALUE_DISPLAY -- requirements
Module: lcd_value_display

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_write_strobe.sv | 65 ++++++
 rtl/lcd_value_display.sv | 187 ++++++++++++++++++
 tb/tb_lcd_value_display.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM states and digit encoding for the HD44780 value display.
package lcd_pkg;

    localparam logic [7:0] CMD_DISP_ON = 8'h0E;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_LINE0   = 8'h80;
    localparam logic [7:0] CMD_LINE1   = 8'hC0;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [2:0] {INIT, IDLE, ADDR, CHAR, WRAP, DONE} state_e;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        if (d < 4'd10) return ASCII_ZERO + {4'd0, d};
        return ASCII_A + {4'd0, d} - 8'd10;
    endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One HD44780 byte write: setup cycle, PULSE_CYC cycles of en high, hold cycle.
// A new go may be accepted in the hold cycle so writes can run back to back.
module lcd_write_strobe #(
    parameter int PULSE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] wr_byte,
    input  logic       rs,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       last
);

    localparam int LAST_CYC = PULSE_CYC + 1;
    localparam int CW       = $clog2(LAST_CYC + 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic          act_q, act_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;

    always_comb begin
        cyc_d  = cyc_q;
        act_d  = act_q;
        data_d = data_q;
        rs_d   = rs_q;
        if (act_q) begin
            if (cyc_q == CW'(LAST_CYC)) begin
                act_d = 1'b0;
                cyc_d = '0;
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end
        if (go) begin
            act_d  = 1'b1;
            cyc_d  = '0;
            data_d = wr_byte;
            rs_d   = rs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            act_q  <= 1'b0;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            act_q  <= act_d;
            data_q <= data_d;
            rs_q   <= rs_d;
        end
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_en   = act_q && (cyc_q != '0) && (cyc_q != CW'(LAST_CYC));
    assign last     = act_q && (cyc_q == CW'(LAST_CYC));

endmodule

// File: rtl/lcd_value_display.sv
// Prints a binary or hex number on a 2x16 HD44780 display, wrapping to the
// other line after 16 characters.
module lcd_value_display #(
    parameter int DATA_W     = 18,
    parameter int PULSE_CYC  = 2,
    parameter int CLEAR_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic              line,
    input  logic              radix,
    output logic              busy,
    output logic              done,
    output logic [7:0]        lcd_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en
);

    import lcd_pkg::*;

    localparam logic [5:0] NCH_BIN = 6'(DATA_W);
    localparam logic [5:0] NCH_HEX = 6'((DATA_W + 3) / 4);

    state_e            state_q, state_d;
    logic              sent_q, sent_d;
    logic [1:0]        step_q, step_d;
    logic [15:0]       wait_q, wait_d;
    logic [5:0]        idx_q, idx_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              line_q, line_d;
    logic              radix_q, radix_d;

    logic              go, wr_last, wr_rs;
    logic [7:0]        wr_byte;
    logic [5:0]        nchars, idx_inc, pos;
    logic [31:0]       val_ext;
    logic [3:0]        digit;

    assign nchars  = radix_q ? NCH_HEX : NCH_BIN;
    assign idx_inc = idx_q + 6'd1;

    // sent_q marks that the current state's byte is already in the strobe;
    // every follow-on byte is launched in the hold cycle of the previous one.
    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        step_d  = step_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        val_d   = val_q;
        line_d  = line_q;
        radix_d = radix_q;
        go      = 1'b0;
        case (state_q)
            INIT: begin
                if (!sent_q) begin
                    if (wait_q == 16'd0) begin
                        go     = 1'b1;
                        sent_d = 1'b1;
                    end else begin
                        wait_d = wait_q - 16'd1;
                    end
                end else if (wr_last) begin
                    if (step_q == 2'd3) begin
                        state_d = IDLE;
                        sent_d  = 1'b0;
                    end else begin
                        step_d = step_q + 2'd1;
                        if (step_q == 2'd2 && CLEAR_WAIT > 0) begin
                            sent_d = 1'b0;
                            wait_d = 16'(CLEAR_WAIT - 1);
                        end else begin
                            go = 1'b1;
                        end
                    end
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                sent_d  = 1'b0;
                if (start) begin
                    state_d = ADDR;
                    val_d   = value;
                    line_d  = line;
                    radix_d = radix;
                end
            end
            ADDR: begin
                if (!sent_q) begin
                    go     = 1'b1;
                    sent_d = 1'b1;
                end else if (wr_last) begin
                    state_d = CHAR;
                    idx_d   = 6'd0;
                    go      = 1'b1;
                end
            end
            CHAR: begin
                if (wr_last) begin
                    if (idx_inc == nchars) begin
                        state_d = DONE;
                        sent_d  = 1'b0;
                    end else begin
                        idx_d = idx_inc;
                        go    = 1'b1;
                        if (idx_inc == 6'd16) state_d = WRAP;
                    end
                end
            end
            WRAP: begin
                if (wr_last) begin
                    state_d = CHAR;
                    go      = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Byte for the write being launched, chosen from the state it belongs to.
    always_comb begin
        val_ext = 32'(val_q);
        pos     = nchars - 6'd1 - idx_d;
        digit   = radix_q ? 4'(val_ext >> {pos, 2'b00}) : {3'b000, 1'(val_ext >> pos)};
        wr_byte = 8'h00;
        wr_rs   = 1'b0;
        case (state_d)
            INIT: begin
                case (step_d)
                    2'd0:    wr_byte = CMD_DISP_ON;
                    2'd1:    wr_byte = CMD_ENTRY;
                    2'd2:    wr_byte = CMD_CLEAR;
                    default: wr_byte = CMD_HOME;
                endcase
            end
            ADDR: wr_byte = line_q ? CMD_LINE1 : CMD_LINE0;
            WRAP: wr_byte = line_q ? CMD_LINE0 : CMD_LINE1;
            CHAR: begin
                wr_byte = digit_ascii(digit);
                wr_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            sent_q  <= 1'b0;
            step_q  <= 2'd0;
            wait_q  <= 16'd0;
            idx_q   <= 6'd0;
            val_q   <= '0;
            line_q  <= 1'b0;
            radix_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            step_q  <= step_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            line_q  <= line_d;
            radix_q <= radix_d;
        end
    end

    lcd_write_strobe #(.PULSE_CYC(PULSE_CYC)) u_strobe (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .wr_byte  (wr_byte),
        .rs       (wr_rs),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .last     (wr_last)
    );

    assign lcd_rw = 1'b0;
    assign busy   = !(state_q == IDLE || state_q == DONE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_lcd_value_display.sv
// Scoreboard bench: stimulus pushes expected bus writes from a reference model,
// monitors pop and compare on every lcd_en rise and every done pulse.
module tb_lcd_value_display;

    localparam int PULSE_CYC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, line = 1'b0, radix = 1'b0;
    logic [17:0] value = '0;
    logic        busy, done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]  lcd_data;

    logic        rst2 = 1'b1, start2 = 1'b0, line2 = 1'b0, radix2 = 1'b0;
    logic [0:0]  value2 = '0;
    logic        busy2, done2, rs2, rw2, en2;
    logic [7:0]  data2;

    lcd_value_display #(.DATA_W(18), .PULSE_CYC(PULSE_CYC), .CLEAR_WAIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .line(line), .radix(radix),
        .busy(busy), .done(done), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en)
    );

    lcd_value_display #(.DATA_W(1), .PULSE_CYC(PULSE_CYC), .CLEAR_WAIT(4)) dut1 (
        .clk(clk), .rst(rst2), .start(start2), .value(value2), .line(line2), .radix(radix2),
        .busy(busy2), .done(done2), .lcd_data(data2), .lcd_rs(rs2), .lcd_rw(rw2),
        .lcd_en(en2)
    );

    int tests = 0, fails = 0, wr_cnt = 0;
    int done_pend0 = 0, done_pend1 = 0;
    logic [9:0] exp0[$];
    logic [9:0] exp1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h, nothing expected", name, act);
    endtask

    task automatic exp_push(input int which, input logic [9:0] b);
        if (which == 0) exp0.push_back(b);
        else exp1.push_back(b);
    endtask

    task automatic push_init(input int which);
        exp_push(which, 10'h00E);
        exp_push(which, 10'h006);
        exp_push(which, 10'h001);
        exp_push(which, 10'h002);
    endtask

    // Reference model: address, then digits MSB first, other-line address after 16.
    task automatic push_display(input int which, input int w, input longint unsigned v,
                                input bit l, input bit r);
        int n;
        n = r ? (w + 3) / 4 : w;
        exp_push(which, {2'b00, l ? 8'hC0 : 8'h80});
        for (int i = 0; i < n; i++) begin
            int unsigned d;
            logic [7:0]  ch;
            if (i == 16) exp_push(which, {2'b00, l ? 8'h80 : 8'hC0});
            d  = r ? int'((v >> (4 * (n - 1 - i))) & 64'hF) : int'((v >> (w - 1 - i)) & 64'h1);
            ch = (d < 10) ? 8'(48 + d) : 8'(55 + d);
            exp_push(which, {2'b01, ch});
        end
        if (which == 0) done_pend0++;
        else done_pend1++;
    endtask

    function automatic int disp_cycles(input int w, input bit r);
        int n;
        n = r ? (w + 3) / 4 : w;
        return (1 + n + ((n > 16) ? 1 : 0)) * (PULSE_CYC + 2) + 1;
    endfunction

    // Monitor for the 18-bit instance: byte, setup, pulse width, hold and done.
    logic       en_prev0 = 1'b0;
    int         hi_len0 = 0;
    logic [9:0] cur0 = '0, prev_bus0 = '0;
    always @(negedge clk) begin
        if (lcd_en && !en_prev0) begin
            wr_cnt++;
            cur0    = {lcd_rw, lcd_rs, lcd_data};
            hi_len0 = 1;
            check("setup0", prev_bus0, cur0);
            if (exp0.size() == 0) fail_now("write0_unexpected", cur0);
            else check("write0", cur0, 32'(exp0.pop_front()));
        end else if (lcd_en) begin
            hi_len0++;
        end else if (en_prev0 && !rst) begin
            check("en_width0", hi_len0, PULSE_CYC);
            check("hold0", {lcd_rw, lcd_rs, lcd_data}, cur0);
        end
        if (done) begin
            if (done_pend0 == 0) fail_now("done0_unexpected", 1);
            else begin
                done_pend0--;
                check("done0_busy", busy, 0);
            end
        end
        en_prev0  = lcd_en;
        prev_bus0 = {lcd_rw, lcd_rs, lcd_data};
    end

    logic en_prev1 = 1'b0;
    always @(negedge clk) begin
        if (en2 && !en_prev1) begin
            if (exp1.size() == 0) fail_now("write1_unexpected", {rw2, rs2, data2});
            else check("write1", {rw2, rs2, data2}, 32'(exp1.pop_front()));
        end
        if (done2) begin
            if (done_pend1 == 0) fail_now("done1_unexpected", 1);
            else done_pend1--;
        end
        en_prev1 = en2;
    end

    task automatic do_reset(input int which);
        int n;
        if (which == 0) begin rst = 1'b1; exp0.delete(); done_pend0 = 0; end
        else begin rst2 = 1'b1; exp1.delete(); done_pend1 = 0; end
        start = 1'b0;
        start2 = 1'b0;
        push_init(which);
        @(posedge clk); #1;
        if (which == 0) begin
            check("rst_en", lcd_en, 0);
            check("rst_rs", lcd_rs, 0);
            check("rst_rw", lcd_rw, 0);
            check("rst_data", lcd_data, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 1);
        end else begin
            check("rst1_en", en2, 0);
            check("rst1_busy", busy2, 1);
        end
        repeat (2) @(posedge clk);
        #1;
        if (which == 0) rst = 1'b0;
        else rst2 = 1'b0;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (((which == 0) ? busy : busy2) && n < 100);
        check("init_busy_cycles", n, 20);
    endtask

    task automatic wait_idle(input int which);
        for (int i = 0; i < 400; i++) begin
            if (((which == 0) ? busy : busy2) == 1'b0) return;
            @(negedge clk); #1;
        end
        fail_now("idle_timeout", which);
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (((which == 0) ? done : done2) == 1'b1) return;
        end
        fail_now("done_timeout", which);
    endtask

    task automatic start_disp(input int which, input longint unsigned v, input bit l, input bit r);
        wait_idle(which);
        if (which == 0) begin start = 1'b1; value = v[17:0]; line = l; radix = r; end
        else begin start2 = 1'b1; value2 = v[0:0]; line2 = l; radix2 = r; end
        push_display(which, (which == 0) ? 18 : 1, v, l, r);
        @(posedge clk); #1;
        start = 1'b0;
        start2 = 1'b0;
        check("start_accepted", (which == 0) ? busy : busy2, 1);
    endtask

    // Called right after the accepting edge; checks first en rise and done latency.
    task automatic measure(input int w, input bit r);
        int n, first_en;
        n = 0;
        first_en = -1;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (lcd_en && first_en < 0) first_en = n;
        end while (!done && n < 300);
        check("first_en_rise", first_en, 2);
        check("start_to_done", n, disp_cycles(w, r));
    endtask

    initial begin
        do_reset(0);

        start_disp(0, 64'h2A5F3, 1'b0, 1'b1);
        measure(18, 1'b1);
        start_disp(0, 64'h2A5F3, 1'b1, 1'b0);
        measure(18, 1'b0);

        // Start while busy must be ignored.
        start_disp(0, 64'h12345, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        start = 1'b1; value = 18'h3FFFF; line = 1'b1; radix = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(0);

        for (int k = 0; k < 16; k++) begin
            longint unsigned v;
            v = longint'($urandom_range(0, 18'h3FFFF));
            if (k == 0) v = 0;
            if (k == 1) v = 18'h3FFFF;
            start_disp(0, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done(0);
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1;
            end
        end

        // Abort during the third character's en-high phase.
        wait_idle(0);
        wr_cnt = 0;
        start_disp(0, 64'h0ABCD, 1'b0, 1'b0);
        for (int i = 0; i < 200 && !(wr_cnt == 4 && lcd_en); i++) begin
            @(negedge clk); #1;
        end
        check("abort_reached_char3", wr_cnt, 4);
        do_reset(0);
        start_disp(0, 64'h2A5F3, 1'b0, 1'b1);
        wait_done(0);

        do_reset(1);
        start_disp(1, 64'h1, 1'b0, 1'b1);
        wait_done(1);
        start_disp(1, 64'h0, 1'b1, 1'b0);
        wait_done(1);
        start_disp(1, 64'h1, 1'b1, 1'b0);
        wait_done(1);

        repeat (10) @(negedge clk);
        #1;
        check("queue0_drained", exp0.size(), 0);
        check("done0_drained", done_pend0, 0);
        check("queue1_drained", exp1.size(), 0);
        check("done1_drained", done_pend1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
